// File: rtl/multi_edge_counter.sv
// multi_edge_counter: NUM_CH independent edge counters on asynchronous inputs.
// Each channel has a synchroniser chain, runtime edge mode, count-enable gating,
// atomic snapshot-and-clear and a sticky overflow flag.
// Optional macro EDGE_CNT_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module multi_edge_counter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       s_in,
    input  logic                    enable,
    input  logic [1:0]              edge_mode,
    input  logic                    clear,
    input  logic                    snap_req,
    output logic [NUM_CH-1:0]       edge_pulse,
    output logic [NUM_CH*CNT_W-1:0] count_live,
    output logic [NUM_CH*CNT_W-1:0] snap_count,
    output logic [NUM_CH-1:0]       snap_ovf,
    output logic                    snap_valid,
    output logic [NUM_CH-1:0]       overflow
);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } edge_mode_e;

    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] edge_det;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    // Warm-up counter: masks detection until the sync chain and prev hold real samples.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples the pre-edge values of the others.
        if (reset) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_DONE) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    assign warm = (warm_cnt != WARM_DONE);

    // Synchroniser chain plus previous-value register per channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= s_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge qualification by mode; prev always tracks the input, so a mode switch never fakes an edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall     = ~sync_q[SYNC_STAGES-1] & prev_q;
        edge_det = '0;
        case (edge_mode_e'(edge_mode))
            MODE_RISE: edge_det = rise;
            MODE_FALL: edge_det = fall;
            MODE_BOTH: edge_det = rise | fall;
            MODE_NONE: edge_det = '0;
            default:   edge_det = '0;
        endcase
        if (warm) begin
            edge_det = '0;
        end
    end

    // Registered edge pulse, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_pulse <= '0;
        end else begin
            edge_pulse <= edge_det;
        end
    end

    // Per-channel counters and sticky overflow; clear/snapshot restart at 0 or 1 so no edge is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: cnt_q is a small register array, not a RAM, so it is reset like any other state.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear || snap_req) begin
                    cnt_q[i]    <= CNT_W'(edge_pulse[i] & enable);
                    overflow[i] <= 1'b0;
                end else if (edge_pulse[i] && enable) begin
`ifdef EDGE_CNT_SATURATE_EN
                    if (cnt_q[i] == CNT_MAX) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
`else
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                    if (cnt_q[i] == CNT_MAX) begin
                        overflow[i] <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Flatten the counter array onto the live output bus.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign count_live[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // Snapshot capture of pre-clear counters and flags, with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_count <= '0;
            snap_ovf   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap_req;
            if (snap_req) begin
                snap_count <= count_live;
                snap_ovf   <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Self-checking bench for multi_edge_counter: directed scenarios plus randomized
// segments checked against an edge-counting reference model. A second, 2-bit
// single-channel instance exercises wrap/saturation.
module tb_multi_edge_counter;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int S      = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       s_in;
    logic                    enable;
    logic [1:0]              edge_mode;
    logic                    clear;
    logic                    snap_req;
    logic [NUM_CH-1:0]       edge_pulse;
    logic [NUM_CH*CNT_W-1:0] count_live;
    logic [NUM_CH*CNT_W-1:0] snap_count;
    logic [NUM_CH-1:0]       snap_ovf;
    logic                    snap_valid;
    logic [NUM_CH-1:0]       overflow;

    logic [0:0] s_in_w;
    logic [0:0] edge_pulse_w;
    logic [1:0] count_live_w;
    logic [1:0] snap_count_w;
    logic [0:0] snap_ovf_w;
    logic       snap_valid_w;
    logic [0:0] overflow_w;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [CNT_W-1:0]        exp_cnt [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] exp_snap;
    int                      w_edges;

    multi_edge_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .s_in(s_in), .enable(enable), .edge_mode(edge_mode),
        .clear(clear), .snap_req(snap_req), .edge_pulse(edge_pulse), .count_live(count_live),
        .snap_count(snap_count), .snap_ovf(snap_ovf), .snap_valid(snap_valid), .overflow(overflow)
    );

    multi_edge_counter #(.NUM_CH(1), .CNT_W(2), .SYNC_STAGES(S)) dut_w (
        .clk(clk), .reset(reset), .s_in(s_in_w), .enable(enable), .edge_mode(edge_mode),
        .clear(clear), .snap_req(snap_req), .edge_pulse(edge_pulse_w), .count_live(count_live_w),
        .snap_count(snap_count_w), .snap_ovf(snap_ovf_w), .snap_valid(snap_valid_w), .overflow(overflow_w)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n clocks; inputs set afterwards are sampled at the next edge, outputs read here are stable.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit qual(input bit is_rise, input logic [1:0] m);
        return is_rise ? (m == 2'b00 || m == 2'b10) : (m == 2'b01 || m == 2'b10);
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] pack_exp();
        logic [NUM_CH*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = exp_cnt[i];
        return v;
    endfunction

    function automatic logic [1:0] exp_w();
`ifdef EDGE_CNT_SATURATE_EN
        return (w_edges > 3) ? 2'd3 : 2'(w_edges);
`else
        return 2'(w_edges % 4);
`endif
    endfunction

    task automatic zero_model();
        for (int i = 0; i < NUM_CH; i++) exp_cnt[i] = '0;
        w_edges = 0;
    endtask

    task automatic apply_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        zero_model();
    endtask

    // Drive n pulses of width w on one line, drain the pipeline, and count observed edge pulses.
    task automatic drive_pulses(input int ch, input bit on_w, input int n, input int w, output int seen);
        seen = 0;
        for (int p = 0; p < n; p++) begin
            for (int lvl = 1; lvl >= 0; lvl--) begin
                if (on_w) s_in_w[0] = lvl[0];
                else      s_in[ch]  = lvl[0];
                if (qual(lvl[0], edge_mode) && enable) begin
                    if (on_w) w_edges++;
                    else      exp_cnt[ch] = exp_cnt[ch] + 1'b1;
                end
                repeat (w) begin
                    step(1);
                    seen += on_w ? int'(edge_pulse_w[0]) : int'(edge_pulse[ch]);
                end
            end
        end
        repeat (S + 2) begin
            step(1);
            seen += on_w ? int'(edge_pulse_w[0]) : int'(edge_pulse[ch]);
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1; s_in = 4'b0001; s_in_w = 1'b0; enable = 1'b1; edge_mode = 2'b00;
        clear = 1'b0; snap_req = 1'b0;
        zero_model();
        exp_snap = '0;
        step(3);
        n_cmp++;
        if ({edge_pulse, count_live, snap_count, snap_ovf, snap_valid, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: outputs=%h required all zero",
                     {edge_pulse, count_live, snap_count, snap_ovf, snap_valid, overflow});
        end
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            step(1);
            seen += int'(edge_pulse[0]);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL warmup_pulse: saw %0d pulses on ch0, required 0", seen);
        end
        n_cmp++;
        if (count_live[0 +: CNT_W] !== '0) begin
            n_bad++;
            $display("FAIL warmup_count: ch0=%0d required 0", count_live[0 +: CNT_W]);
        end
        s_in[0] = 1'b0;
        step(S + 4);
        n_cmp++;
        if (count_live !== pack_exp()) begin
            n_bad++;
            $display("FAIL falling_ignored: count_live=%h required %h", count_live, pack_exp());
        end
    endtask

    task automatic test_rising();
        int seen;
        edge_mode = 2'b00; enable = 1'b1;
        s_in[1] = 1'b1;
        exp_cnt[1] = exp_cnt[1] + 1'b1;
        step(1);
        for (int j = 1; j <= S + 1; j++) begin
            step(1);
            n_cmp++;
            if (edge_pulse[1] !== (j == S)) begin
                n_bad++;
                $display("FAIL pulse_latency: %0d cycles after sample edge_pulse[1]=%b required %b",
                         j, edge_pulse[1], (j == S));
            end
        end
        s_in[1] = 1'b0;
        step(4);
        drive_pulses(1, 1'b0, 2, 4, seen);
        n_cmp++;
        if (seen !== 2) begin
            n_bad++;
            $display("FAIL rising_pulses: saw %0d required 2", seen);
        end
        n_cmp++;
        if (count_live !== pack_exp()) begin
            n_bad++;
            $display("FAIL rising_count: count_live=%h required %h", count_live, pack_exp());
        end
    endtask

    task automatic test_both();
        int seen;
        edge_mode = 2'b10; enable = 1'b1;
        drive_pulses(2, 1'b0, 2, 4, seen);
        n_cmp++;
        if (seen !== 4) begin
            n_bad++;
            $display("FAIL both_pulses: saw %0d required 4", seen);
        end
        n_cmp++;
        if (count_live !== pack_exp()) begin
            n_bad++;
            $display("FAIL both_count: count_live=%h required %h", count_live, pack_exp());
        end
        enable = 1'b0;
        drive_pulses(2, 1'b0, 2, 4, seen);
        n_cmp++;
        if (seen !== 4) begin
            n_bad++;
            $display("FAIL disabled_pulses: saw %0d required 4", seen);
        end
        n_cmp++;
        if (count_live !== pack_exp()) begin
            n_bad++;
            $display("FAIL disabled_count: count_live=%h required %h", count_live, pack_exp());
        end
        enable = 1'b1;
        edge_mode = 2'b00;
    endtask

    task automatic test_snapshot();
        int seen;
        apply_clear();
        drive_pulses(3, 1'b0, 7, 3, seen);
        s_in[3] = 1'b1;
        step(1 + S);
        n_cmp++;
        if (edge_pulse[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL snap_edge_align: edge_pulse[3]=%b required 1", edge_pulse[3]);
        end
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        exp_snap = pack_exp();
        zero_model();
        exp_cnt[3] = 1;
        n_cmp++;
        if (snap_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL snap_valid: got %b required 1", snap_valid);
        end
        n_cmp++;
        if (snap_count !== exp_snap) begin
            n_bad++;
            $display("FAIL snap_count: got %h required %h", snap_count, exp_snap);
        end
        n_cmp++;
        if (count_live !== pack_exp()) begin
            n_bad++;
            $display("FAIL snap_restart: count_live=%h required %h", count_live, pack_exp());
        end
        step(1);
        n_cmp++;
        if (snap_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL snap_valid_width: got %b required 0", snap_valid);
        end
        s_in[3] = 1'b0;
        step(S + 2);
        // Back-to-back snapshots: each yields a valid pulse, the second captures the restarted counters.
        snap_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(1);
            exp_snap = pack_exp();
            zero_model();
            n_cmp++;
            if (snap_valid !== 1'b1 || snap_count !== exp_snap) begin
                n_bad++;
                $display("FAIL b2b_snap%0d: valid=%b snap=%h required valid=1 snap=%h",
                         k, snap_valid, snap_count, exp_snap);
            end
        end
        snap_req = 1'b0;
        step(1);
        n_cmp++;
        if (snap_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: snap_valid=%b required 0", snap_valid);
        end
    endtask

    task automatic test_wrap();
        int seen;
        apply_clear();
        edge_mode = 2'b00; enable = 1'b1;
        drive_pulses(0, 1'b1, 5, 2, seen);
        n_cmp++;
        if (count_live_w !== exp_w() || overflow_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_count: count=%0d ovf=%b required count=%0d ovf=1",
                     count_live_w, overflow_w[0], exp_w());
        end
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        n_cmp++;
        if (snap_valid_w !== 1'b1 || snap_ovf_w[0] !== 1'b1 || snap_count_w !== exp_w()) begin
            n_bad++;
            $display("FAIL wrap_snap: valid=%b ovf=%b count=%0d required valid=1 ovf=1 count=%0d",
                     snap_valid_w, snap_ovf_w[0], snap_count_w, exp_w());
        end
        exp_snap = pack_exp();
        zero_model();
        n_cmp++;
        if (overflow_w[0] !== 1'b0 || count_live_w !== 2'd0) begin
            n_bad++;
            $display("FAIL wrap_after_snap: ovf=%b count=%0d required ovf=0 count=0",
                     overflow_w[0], count_live_w);
        end
    endtask

    task automatic test_clear_snap();
        int seen;
        apply_clear();
        drive_pulses(0, 1'b0, 5, 2, seen);
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        exp_snap = pack_exp();
        zero_model();
        drive_pulses(1, 1'b0, 2, 2, seen);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        zero_model();
        n_cmp++;
        if (snap_valid !== 1'b0 || snap_count !== exp_snap || count_live !== '0) begin
            n_bad++;
            $display("FAIL clear_only: valid=%b snap=%h live=%h required valid=0 snap=%h live=0",
                     snap_valid, snap_count, count_live, exp_snap);
        end
        drive_pulses(0, 1'b0, 5, 2, seen);
        clear = 1'b1; snap_req = 1'b1;
        step(1);
        clear = 1'b0; snap_req = 1'b0;
        exp_snap = pack_exp();
        zero_model();
        n_cmp++;
        if (snap_valid !== 1'b1 || snap_count !== exp_snap || snap_count[0 +: CNT_W] !== 16'd5) begin
            n_bad++;
            $display("FAIL clear_snap_capture: valid=%b snap=%h required valid=1 snap=%h",
                     snap_valid, snap_count, exp_snap);
        end
        n_cmp++;
        if (count_live !== '0 || overflow !== '0 || snap_ovf !== '0) begin
            n_bad++;
            $display("FAIL clear_snap_zero: live=%h ovf=%b snap_ovf=%b required all 0",
                     count_live, overflow, snap_ovf);
        end
    endtask

    // Randomized segments: mode and enable fixed per segment, lines toggle randomly each cycle.
    task automatic test_random();
        int exp_pulse [NUM_CH];
        int seen [NUM_CH];
        logic [NUM_CH-1:0] old_v;
        logic [NUM_CH-1:0] new_v;
        for (int seg = 0; seg < 8; seg++) begin
            edge_mode = 2'($urandom_range(0, 3));
            enable    = 1'($urandom_range(0, 1));
            step(1);
            for (int i = 0; i < NUM_CH; i++) begin
                exp_pulse[i] = 0;
                seen[i] = 0;
            end
            for (int c = 0; c < 60 + S + 2; c++) begin
                if (c < 60) begin
                    old_v = s_in;
                    new_v = NUM_CH'($urandom);
                    s_in  = new_v;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (old_v[i] != new_v[i] && qual(new_v[i], edge_mode)) begin
                            exp_pulse[i]++;
                            if (enable) exp_cnt[i] = exp_cnt[i] + 1'b1;
                        end
                    end
                end
                step(1);
                for (int i = 0; i < NUM_CH; i++) seen[i] += int'(edge_pulse[i]);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                n_cmp++;
                if (seen[i] !== exp_pulse[i]) begin
                    n_bad++;
                    $display("FAIL rand_pulses seg%0d ch%0d mode=%b: saw %0d required %0d",
                             seg, i, edge_mode, seen[i], exp_pulse[i]);
                end
            end
            n_cmp++;
            if (count_live !== pack_exp() || overflow !== '0) begin
                n_bad++;
                $display("FAIL rand_count seg%0d mode=%b en=%b: live=%h ovf=%b required live=%h ovf=0",
                         seg, edge_mode, enable, count_live, overflow, pack_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_both();
        test_snapshot();
        test_wrap();
        test_clear_snap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_edge_counter.md
Name: multi_edge_counter

Overview:
- Parametrised successor to the single-channel 4-bit rising-edge counter: NUM_CH independent channels with configurable counter width and an input synchroniser per channel.
- Runtime edge mode (rising/falling/both), count-enable gating, atomic snapshot-and-clear, and sticky per-channel overflow flags.
- Sits between asynchronous pulse/trigger lines (stim markers, sync pulses) and the register/readout logic that polls counts at fixed intervals.

Parameters:
- NUM_CH, 4, number of independent input channels (1..32)
- CNT_W, 16, counter width per channel in bits (2..32)
- SYNC_STAGES, 2, synchroniser flops per channel input (2..4)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- s_in  input  NUM_CH  asynchronous input signals, bit i = channel i
- enable  input  1  1 = detected edges increment counters; 0 = detection continues, counting frozen
- edge_mode  input  2  00 rising, 01 falling, 10 both, 11 none (detection off)
- clear  input  1  single-cycle pulse: zero all counters and overflow flags
- snap_req  input  1  single-cycle pulse: capture all counters, then restart them
- edge_pulse  output  NUM_CH  registered one-cycle pulse per detected edge (independent of enable)
- count_live  output  NUM_CH*CNT_W  live counters; channel i at bits [i*CNT_W +: CNT_W]
- snap_count  output  NUM_CH*CNT_W  captured counters, held until the next snapshot
- snap_ovf  output  NUM_CH  overflow flags captured with snap_count
- snap_valid  output  1  one-cycle pulse: snap_count/snap_ovf updated
- overflow  output  NUM_CH  sticky live overflow flag per channel

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk, reset port reset.
- Reset: sync chain, previous-value regs, edge_pulse, count_live, snap_count, snap_ovf, snap_valid and overflow all 0.
- Warm-up: a counter of SYNC_STAGES+1 cycles after reset deassert masks edge detection, so a line held high through reset is not counted. Reset asserted mid-operation restarts warm-up.
- Pipeline:
  - s_in passes through SYNC_STAGES flops; prev register holds the last synchronised value.
  - edge_pulse[i] is registered from (sync, prev) per edge_mode.
  - A transition sampled at clock edge k gives edge_pulse high for the cycle after edge k+SYNC_STAGES. count_live changes at the following edge.
- Count update per channel, each cycle:
  - clear or snap_req: counter loads 0 + (edge_pulse[i] & enable). No edge is lost across a snapshot or clear.
  - else if edge_pulse[i] & enable: counter increments.
  - else: counter holds.
- Wrap, without the macro: all-ones + 1 wraps to 0 and sets overflow[i] (sticky).
- Snapshot:
  - snap_req at edge k loads snap_count and snap_ovf with the pre-clear counters/flags and pulses snap_valid high for the following cycle.
  - overflow is cleared in the same update; an edge in that cycle that overflows is impossible, since the counter restarts at 0/1.
- clear:
  - Zeroes counters and overflow; does not touch snap_count or snap_ovf; no snap_valid.
  - clear and snap_req in the same cycle: the snapshot is taken (pre-clear values), then everything zeroes. Same result as snap_req alone.
  - Back-to-back snap_req on consecutive cycles is legal; each produces a snap_valid pulse.
- edge_mode change takes effect the next cycle. prev keeps tracking the input, so no false edge is produced by the switch. Mode 11 forces edge_pulse = 0.

Optional Feature:
- Macro EDGE_CNT_SATURATE_EN.
- Defined: counters saturate at 2^CNT_W-1. An increment attempted at max holds the value and sets overflow[i].
- Undefined: counters wrap to 0 and set overflow[i] as above.
- All other behaviour is identical.

Test Plan:
- Reset with s_in[0]=1 held, release reset, wait 10 cycles -> count_live ch0 = 0, no edge_pulse.
- edge_mode=00, enable=1, 3 rising pulses on ch1 (each 4 cycles wide) -> ch1 = 3, others 0; first edge_pulse exactly SYNC_STAGES+1 cycles after the sampled transition.
- edge_mode=10, 2 full pulses on ch2 -> ch2 = 4. Repeat with enable=0 -> edge_pulse still fires, count stays 4.
- Count ch3 to 7, then assert snap_req on the same cycle an edge_pulse occurs -> snap_count ch3 = 7, snap_valid for 1 cycle, count_live ch3 = 1.
- CNT_W=2, 5 edges on ch0:
  - Without macro -> count 1, overflow[0]=1.
  - With EDGE_CNT_SATURATE_EN -> count 3, overflow[0]=1.
  - Then snap_req -> snap_ovf[0]=1, overflow[0]=0.
- clear and snap_req together with ch0=5 -> snap_count ch0 = 5, count_live = 0, overflow all 0.
